lcd_bus_responder: RTL and testbench
====================================

# lcd_bus_responder

Character-LCD bus responder for the calculator top level: it is the display-side end of the `lcd_e`/`lcd_rs`/`lcd_rw`/`lcd_data` interface that the calculator drives. It decodes HD44780-style instruction and data writes into a 2×16 DDRAM character buffer, maintains the address counter and busy flag, and answers status and data reads. The buffer is exposed through a registered read port, so benches and the on-board mirror logic can check displayed text directly.

## Interface
- `BUSY_CYCLES`, default 40: busy duration after any accepted instruction or data write except clear/home.
- `CLEAR_BUSY_CYCLES`, default 1600: busy duration after clear (0x01) or return home (0x02/0x03).

- `clk`  in  1: single system clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `lcd_e`  in  1: enable strobe; a transaction commits on its falling edge.
- `lcd_rs`  in  1: 0 = instruction/status, 1 = data.
- `lcd_rw`  in  1: 0 = write, 1 = read.
- `lcd_data`  in  8: write data from the initiator.
- `lcd_dout`  out  8: read data returned to the initiator.
- `lcd_doe`  out  1: high while `lcd_dout` is valid, which is while `lcd_e` is high with `lcd_rw` = 1.
- `rd_addr`  in  5: buffer index; `{line, column[3:0]}`.
- `rd_char`  out  8: registered `DDRAM[rd_addr]`.
- `busy`  out  1: the busy flag.
- `disp_on`  out  1: display-on bit from the last display-control instruction.
- `ovr_err`  out  1: sticky flag, set when a write is dropped because `busy` was high.

## Operation
- Each cycle, `lcd_e`, `lcd_rs`, `lcd_rw` and `lcd_data` are registered as `e_d`, `rs_d`, `rw_d` and `data_d`.
- A strobe occurs when `e_d` = 1 and `lcd_e` = 0. The transaction uses `rs_d`, `rw_d` and `data_d`.
- AC is a 5-bit index. It is reported externally as a 7-bit address `{AC[4], 2'b00, AC[3:0]}`, so line 1 occupies 0x00–0x0F and line 2 occupies 0x40–0x4F.
- Writes while `busy` = 1 are dropped and set `ovr_err`. Reads are always honoured.
- Instruction writes, decoded by the highest set bit:
  - 0x01 clear: all 32 cells ← 0x20; AC ← 0; I/D ← 1.
  - 0x02/0x03 home: AC ← 0; buffer unchanged.
  - 0x04–0x07 entry mode: I/D ← bit1; the S bit is ignored.
  - 0x08–0x0F display control: `disp_on` ← bit2.
  - 0x10–0x1F shift: if bit3 = 0, AC moves right when bit2 = 1 and left when bit2 = 0; if bit3 = 1, no effect.
  - 0x20–0x3F function set and 0x40–0x7F CGRAM address: accepted, apply busy, otherwise no effect.
  - 0x80–0xFF set DDRAM address: AC ← `{d[6], d[3:0]}`. Out-of-range addresses therefore fold onto a line.
- Data write: `DDRAM[AC]` ← data, then AC steps according to I/D.
- Status read (rs = 0, rw = 1): `lcd_dout` = `{busy, AC7}`, where AC7 is the 7-bit reported address.
- Data read (rs = 1, rw = 1): `lcd_dout` = `DDRAM[AC]`; AC steps on the strobe.
- AC stepping wraps as follows:
  - increment: 0x0F → 0x40 and 0x4F → 0x00;
  - decrement: 0x00 → 0x4F and 0x40 → 0x0F.
- Busy counter: loaded on an accepted write with `BUSY_CYCLES` or `CLEAR_BUSY_CYCLES` and decremented every cycle. `busy` = (count ≠ 0).

## Timing
- Reset values:
  - `lcd_dout` = 0x00; `lcd_doe` = 0; `busy` = 0; `disp_on` = 0; `ovr_err` = 0; `rd_char` = 0x20.
  - All DDRAM cells = 0x20; AC = 0; I/D = 1; busy count = 0.
- Reset asserted mid-busy or mid-strobe aborts immediately; the pending strobe is lost.
- Commit: state updates on the clock edge at which the strobe is detected.
  - `busy` reads 1 from the next cycle, for exactly N cycles.
  - `rd_char` shows the new cell 1 cycle after commit.
- `rd_char` latency: 1 cycle from a change of `rd_addr`.
- `lcd_dout`/`lcd_doe` are registered:
  - they are valid from the cycle after `e_d` rises with rw = 1;
  - they hold the value sampled at that point until `e_d` falls;
  - afterwards `lcd_doe` = 0 and `lcd_dout` holds its value.
- A data write and a simultaneous `rd_addr` read of the same cell: `rd_char` shows the old value that cycle and the new value the next.
- A strobe on the same edge as busy expiry (count = 1) is dropped; a strobe at count = 0 is accepted.
- A minimum `lcd_e` high time of 1 clock is required; shorter pulses are not detected.

## Configuration
- `LCD_BUSY_MODEL_EN` defined: busy counting, write dropping and `ovr_err` operate as above.
- `LCD_BUSY_MODEL_EN` undefined:
  - the busy counter is removed;
  - `busy` is tied to 0 and `ovr_err` is tied to 0;
  - every write is accepted;
  - status reads return 0 in bit7.

## Test plan
- Reset, then write 0x01, wait 1600 cycles, write data 0x34 then 0x35 → cells 0x00 = 0x34 and 0x01 = 0x35; AC = 0x02; status read = 0x02.
- Write 0x8F, data 0x41, data 0x42 → cell idx 15 = 0x41, idx 16 (addr 0x40) = 0x42; status read = 0x41. Repeat at 0xCF → wrap to 0x00.
- Write 0x04 (decrement), 0x80, data 0x58 → idx 0 = 0x58; AC = 0x4F.
- Write data 0x37, then data 0x38 two cycles later → 0x38 dropped; `ovr_err` = 1; busy is high for 40 cycles; build without `LCD_BUSY_MODEL_EN` → both written and `ovr_err` = 0.
- Data read at AC = 0 after writing 0x39 → `lcd_doe` = 1 and `lcd_dout` = 0x39; AC = 1 after the strobe.
- Assert `rst` during a clear busy period → `busy` = 0, all cells = 0x20 and `rd_char` = 0x20 immediately; `disp_on` = 0.

Source files
------------

// File: rtl/lcd_bus_responder.sv
// rtl/lcd_bus_responder.sv - HD44780-style character LCD bus responder with 2x16 DDRAM buffer
// Optional busy model (busy counter, write dropping, ovr_err): define LCD_BUSY_MODEL_EN.
module lcd_bus_responder #(
  parameter int BUSY_CYCLES       = 40,
  parameter int CLEAR_BUSY_CYCLES = 1600
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_lcd_e,
  input  logic       i_lcd_rs,
  input  logic       i_lcd_rw,
  input  logic [7:0] i_lcd_data,
  output logic [7:0] o_lcd_dout,
  output logic       o_lcd_doe,
  input  logic [4:0] i_rd_addr,
  output logic [7:0] o_rd_char,
  output logic       o_busy,
  output logic       o_disp_on,
  output logic       o_ovr_err
);

  logic       r_e_d, r_rs_d, r_rw_d;
  logic [7:0] r_data_d;
  logic [7:0] r_ddram [32];
  logic [4:0] r_ac;
  logic       r_id, r_disp_on, r_doe;
  logic [7:0] r_dout, r_rd_char;

  logic       w_strobe, w_wr, w_rd, w_busy, w_accept, w_clear, w_long;
  logic [4:0] w_ac_next, w_ac_step;
  logic       w_id_next, w_disp_next;
  logic [7:0] w_status;

  assign w_strobe  = r_e_d & ~i_lcd_e;
  assign w_wr      = w_strobe & ~r_rw_d;
  assign w_rd      = w_strobe & r_rw_d;
  assign w_accept  = w_wr & ~w_busy;
  // The 5-bit index wraps line 1 end into line 2 start and vice versa, so plain +/-1 suffices.
  assign w_ac_step = r_id ? r_ac + 5'd1 : r_ac - 5'd1;
  assign w_status  = {w_busy, r_ac[4], 2'b00, r_ac[3:0]};

  always_comb begin
    w_ac_next   = r_ac;
    w_id_next   = r_id;
    w_disp_next = r_disp_on;
    w_clear     = 1'b0;
    w_long      = 1'b0;
    if ((w_accept || w_rd) && r_rs_d) begin
      w_ac_next = w_ac_step;
    end else if (w_accept) begin
      casez (r_data_d)
        8'b1???????: w_ac_next = {r_data_d[6], r_data_d[3:0]};
        8'b01??????, 8'b001?????: begin end
        8'b0001????: begin
          if (!r_data_d[3]) w_ac_next = r_data_d[2] ? r_ac + 5'd1 : r_ac - 5'd1;
        end
        8'b00001???: w_disp_next = r_data_d[2];
        8'b000001??: w_id_next = r_data_d[1];
        8'b0000001?: begin
          w_ac_next = '0;
          w_long    = 1'b1;
        end
        8'b00000001: begin
          w_ac_next = '0;
          w_id_next = 1'b1;
          w_clear   = 1'b1;
          w_long    = 1'b1;
        end
        default: begin end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_e_d     <= 1'b0;
      r_rs_d    <= 1'b0;
      r_rw_d    <= 1'b0;
      r_data_d  <= 8'h00;
      r_ac      <= 5'd0;
      r_id      <= 1'b1;
      r_disp_on <= 1'b0;
    end else begin
      r_e_d     <= i_lcd_e;
      r_rs_d    <= i_lcd_rs;
      r_rw_d    <= i_lcd_rw;
      r_data_d  <= i_lcd_data;
      r_ac      <= w_ac_next;
      r_id      <= w_id_next;
      r_disp_on <= w_disp_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) r_ddram[i] <= 8'h20;
    end else if (w_clear) begin
      for (int i = 0; i < 32; i++) r_ddram[i] <= 8'h20;
    end else if (w_accept && r_rs_d) begin
      r_ddram[r_ac] <= r_data_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_char <= 8'h20;
    end else begin
      r_rd_char <= r_ddram[i_rd_addr];
    end
  end

  // Read data is captured once per enable pulse and held after the pulse ends.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dout <= 8'h00;
      r_doe  <= 1'b0;
    end else if (r_e_d && r_rw_d && !r_doe) begin
      r_doe  <= 1'b1;
      r_dout <= r_rs_d ? r_ddram[r_ac] : w_status;
    end else if (!r_e_d) begin
      r_doe  <= 1'b0;
    end
  end

`ifdef LCD_BUSY_MODEL_EN
  localparam int MAX_BUSY = (CLEAR_BUSY_CYCLES > BUSY_CYCLES) ? CLEAR_BUSY_CYCLES : BUSY_CYCLES;
  localparam int CW       = $clog2(MAX_BUSY + 1);

  logic [CW-1:0] r_busy_cnt;
  logic          r_ovr_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy_cnt <= '0;
      r_ovr_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_busy_cnt <= w_long ? CW'(CLEAR_BUSY_CYCLES) : CW'(BUSY_CYCLES);
      end else if (r_busy_cnt != '0) begin
        r_busy_cnt <= r_busy_cnt - CW'(1);
      end
      if (w_wr && w_busy) r_ovr_err <= 1'b1;
    end
  end

  assign w_busy    = (r_busy_cnt != '0);
  assign o_ovr_err = r_ovr_err;
`else
  logic w_unused_busy;
  assign w_unused_busy = w_long ^ (BUSY_CYCLES != CLEAR_BUSY_CYCLES);
  assign w_busy        = 1'b0;
  assign o_ovr_err     = 1'b0;
`endif

  assign o_busy     = w_busy;
  assign o_disp_on  = r_disp_on;
  assign o_lcd_dout = r_dout;
  assign o_lcd_doe  = r_doe;
  assign o_rd_char  = r_rd_char;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb/tb_lcd_bus_responder.sv - scoreboard bench for lcd_bus_responder
module tb_lcd_bus_responder;
`ifdef LCD_BUSY_MODEL_EN
  localparam bit BUSY_EN = 1'b1;
`else
  localparam bit BUSY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] lcd_dout, rd_char;
  logic       lcd_doe, busy, disp_on, ovr_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_mem [32];
  logic [4:0] m_ac;
  logic       m_id;
  logic [7:0] exp_q [$];

  lcd_bus_responder #(.BUSY_CYCLES(40), .CLEAR_BUSY_CYCLES(1600)) dut (
    .i_clk(clk), .i_rst(rst), .i_lcd_e(lcd_e), .i_lcd_rs(lcd_rs), .i_lcd_rw(lcd_rw),
    .i_lcd_data(lcd_data), .o_lcd_dout(lcd_dout), .o_lcd_doe(lcd_doe), .i_rd_addr(rd_addr),
    .o_rd_char(rd_char), .o_busy(busy), .o_disp_on(disp_on), .o_ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
    m_ac = 5'd0;
    m_id = 1'b1;
    exp_q.delete();
  endfunction

  function automatic void model_step();
    m_ac = m_id ? m_ac + 5'd1 : m_ac - 5'd1;
  endfunction

  function automatic void model_instr(input logic [7:0] d);
    if (d[7]) m_ac = {d[6], d[3:0]};
    else if (d[6] || d[5]) m_ac = m_ac;
    else if (d[4]) begin
      if (!d[3]) m_ac = d[2] ? m_ac + 5'd1 : m_ac - 5'd1;
    end
    else if (d[3]) m_ac = m_ac;
    else if (d[2]) m_id = d[1];
    else if (d[1]) m_ac = 5'd0;
    else if (d[0]) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
      m_ac = 5'd0;
      m_id = 1'b1;
    end
  endfunction

  task automatic do_write(input logic rs, input logic [7:0] d, input bit drop);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b0; lcd_data = d; lcd_e = 1'b1;
    @(negedge clk);
    lcd_e = 1'b0;
    if (!drop) begin
      if (rs) begin
        m_mem[m_ac] = d;
        model_step();
      end else begin
        model_instr(d);
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic wr_idle(input logic rs, input logic [7:0] d);
    do_write(rs, d, 1'b0);
    wait_idle();
  endtask

  task automatic do_read(input logic rs, input bit bexp, input string nm);
    logic [7:0] exp;
    exp_q.push_back(rs ? m_mem[m_ac] : {bexp, m_ac[4], 2'b00, m_ac[3:0]});
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
    @(negedge clk);
    lcd_e = 1'b0;
    if (rs) model_step();
    @(negedge clk);
    exp = exp_q.pop_front();
    n_tests++;
    if (lcd_doe !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_doe: got %b required 1", nm, lcd_doe);
    end
    n_tests++;
    if (lcd_dout !== exp) begin
      n_fail++;
      $display("FAIL %s_dout: got %02h required %02h", nm, lcd_dout, exp);
    end
    @(negedge clk);
    lcd_rw = 1'b0;
    n_tests++;
    if (lcd_doe !== 1'b0 || lcd_dout !== exp) begin
      n_fail++;
      $display("FAIL %s_hold: doe=%b dout=%02h required doe=0 dout=%02h", nm, lcd_doe, lcd_dout, exp);
    end
  endtask

  task automatic check_cell(input int idx, input string nm);
    logic [7:0] exp;
    exp_q.push_back(m_mem[idx]);
    @(negedge clk);
    rd_addr = idx[4:0];
    @(negedge clk);
    exp = exp_q.pop_front();
    n_tests++;
    if (rd_char !== exp) begin
      n_fail++;
      $display("FAIL %s: cell %0d got %02h required %02h", nm, idx, rd_char, exp);
    end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (lcd_dout !== 8'h00 || lcd_doe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dout: dout=%02h doe=%b required 00 0", lcd_dout, lcd_doe);
    end
    n_tests++;
    if (busy !== 1'b0 || disp_on !== 1'b0 || ovr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b disp=%b ovr=%b required 0 0 0", busy, disp_on, ovr_err);
    end
    n_tests++;
    if (rd_char !== 8'h20) begin
      n_fail++;
      $display("FAIL reset_rd_char: got %02h required 20", rd_char);
    end
  endtask

  task automatic test_clear_and_data();
    do_write(1'b0, 8'h01, 1'b0);
    @(negedge clk);
    n_tests++;
    if (busy !== BUSY_EN) begin
      n_fail++;
      $display("FAIL clear_busy: got %b required %b", busy, BUSY_EN);
    end
    wait_idle();
    wr_idle(1'b1, 8'h34);
    wr_idle(1'b1, 8'h35);
    check_cell(0, "clr_cell0");
    check_cell(1, "clr_cell1");
    do_read(1'b0, 1'b0, "clr_status");
  endtask

  task automatic test_line_wrap();
    wr_idle(1'b0, 8'h8F);
    wr_idle(1'b1, 8'h41);
    wr_idle(1'b1, 8'h42);
    check_cell(15, "wrap_cell15");
    check_cell(16, "wrap_cell16");
    do_read(1'b0, 1'b0, "wrap1_status");
    wr_idle(1'b0, 8'hCF);
    wr_idle(1'b1, 8'h43);
    wr_idle(1'b1, 8'h44);
    check_cell(31, "wrap_cell31");
    check_cell(0, "wrap_cell0");
    do_read(1'b0, 1'b0, "wrap2_status");
  endtask

  task automatic test_decrement();
    wr_idle(1'b0, 8'h04);
    wr_idle(1'b0, 8'h80);
    wr_idle(1'b1, 8'h58);
    check_cell(0, "dec_cell0");
    do_read(1'b0, 1'b0, "dec_status");
    wr_idle(1'b0, 8'h06);
  endtask

  task automatic test_control_shift();
    wr_idle(1'b0, 8'h0C);
    n_tests++;
    if (disp_on !== 1'b1) begin
      n_fail++;
      $display("FAIL disp_on_set: got %b required 1", disp_on);
    end
    wr_idle(1'b0, 8'h80);
    wr_idle(1'b0, 8'h14);
    wr_idle(1'b0, 8'h10);
    wr_idle(1'b0, 8'h10);
    wr_idle(1'b0, 8'h18);
    wr_idle(1'b0, 8'h28);
    wr_idle(1'b0, 8'h47);
    do_read(1'b0, 1'b0, "shift_status");
    wr_idle(1'b0, 8'h02);
    do_read(1'b0, 1'b0, "home_status");
    wr_idle(1'b0, 8'h08);
    n_tests++;
    if (disp_on !== 1'b0) begin
      n_fail++;
      $display("FAIL disp_on_clr: got %b required 0", disp_on);
    end
  endtask

  task automatic test_data_read();
    wr_idle(1'b0, 8'h80);
    wr_idle(1'b1, 8'h39);
    wr_idle(1'b0, 8'h80);
    do_read(1'b1, 1'b0, "data_read");
    do_read(1'b0, 1'b0, "data_read_ac");
  endtask

  task automatic test_busy_window();
    int c = 0;
    wr_idle(1'b0, 8'h8A);
    do_write(1'b1, 8'h50, 1'b0);
    repeat (100) begin
      @(negedge clk);
      if (busy === 1'b1) c++;
    end
    n_tests++;
    if (c !== (BUSY_EN ? 40 : 0)) begin
      n_fail++;
      $display("FAIL busy_window: got %0d cycles required %0d", c, BUSY_EN ? 40 : 0);
    end
  endtask

  task automatic test_busy_edge();
    wr_idle(1'b0, 8'h88);
    do_write(1'b1, 8'h61, 1'b0);
    repeat (38) @(negedge clk);
    do_write(1'b1, 8'h62, BUSY_EN);
    wait_idle();
    n_tests++;
    if (ovr_err !== BUSY_EN) begin
      n_fail++;
      $display("FAIL edge_ovr: got %b required %b", ovr_err, BUSY_EN);
    end
    do_write(1'b1, 8'h63, 1'b0);
    repeat (39) @(negedge clk);
    do_write(1'b1, 8'h64, 1'b0);
    wait_idle();
    for (int i = 8; i < 12; i++) check_cell(i, "edge_cell");
  endtask

  task automatic test_back_to_back();
    wr_idle(1'b0, 8'h85);
    do_write(1'b1, 8'h37, 1'b0);
    do_write(1'b1, 8'h38, BUSY_EN);
    do_read(1'b0, BUSY_EN, "b2b_status");
    n_tests++;
    if (ovr_err !== BUSY_EN) begin
      n_fail++;
      $display("FAIL b2b_ovr: got %b required %b", ovr_err, BUSY_EN);
    end
    wait_idle();
    check_cell(5, "b2b_cell5");
    check_cell(6, "b2b_cell6");
  endtask

  task automatic test_reset_midbusy();
    wr_idle(1'b0, 8'h0C);
    wr_idle(1'b0, 8'h83);
    wr_idle(1'b1, 8'h55);
    check_cell(3, "pre_rst_cell3");
    do_write(1'b1, 8'h66, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if (busy !== 1'b0 || rd_char !== 8'h20 || disp_on !== 1'b0 || ovr_err !== 1'b0 || lcd_dout !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_async: busy=%b rd_char=%02h disp=%b ovr=%b dout=%02h required 0 20 0 0 00",
               busy, rd_char, disp_on, ovr_err, lcd_dout);
    end
    @(negedge clk);
    rst = 1'b0;
    do_write(1'b0, 8'h01, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_clear_busy: got %b required 0", busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) check_cell(i, "rst_cell");
  endtask

  initial begin
    test_reset();
    test_clear_and_data();
    test_line_wrap();
    test_decrement();
    test_control_shift();
    test_data_read();
    test_busy_window();
    test_busy_edge();
    test_back_to_back();
    test_reset_midbusy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
